step_ctrl: RTL

STEP_CTRL -- requirements
Module: step_ctrl

---
 rtl/step_ctrl.sv | 125 ++++++++++++
 1 files changed

// File: rtl/step_ctrl.sv
// ============================================================================
// Module  : step_ctrl
// Brief   : Run/halt/single-step/breakpoint clock-enable controller for a core.
// Revision: 1.0
// ============================================================================
`default_nettype none

module step_ctrl #(
  parameter int CNT_W       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int ADDR_W      = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              change,
  input  logic              step,
  input  logic [CNT_W-1:0]  burst_len,
  input  logic              bp_en,
  input  logic [ADDR_W-1:0] bp_addr,
  input  logic [ADDR_W-1:0] pc,
  output logic              cpu_en,
  output logic              halted,
  output logic              step_done,
  output logic [31:0]       cycle_cnt
);

  typedef enum logic [1:0] {
    S_RUN   = 2'd0,
    S_HALT  = 2'd1,
    S_STEP  = 2'd2,
    S_BREAK = 2'd3
  } state_t;

  state_t                 r_state;
  logic [SYNC_STAGES-1:0] r_chg_sync;
  logic [SYNC_STAGES-1:0] r_stp_sync;
  logic                   r_stp_prev;
  logic [CNT_W-1:0]       r_count;
  logic                   r_bp_mask;
  logic                   r_step_done;
  logic [31:0]            r_cycle_cnt;

  logic                   w_chg;
  logic                   w_step_rise;
  logic                   w_bp_hit;
  logic [CNT_W-1:0]       w_load;

  assign w_chg       = r_chg_sync[SYNC_STAGES-1];
  assign w_step_rise = r_stp_sync[SYNC_STAGES-1] & ~r_stp_prev;
  assign w_bp_hit    = bp_en && (pc == bp_addr) && !r_bp_mask;
  // A zero burst length still grants one enabled cycle.
  assign w_load      = (burst_len == '0) ? {{(CNT_W-1){1'b0}}, 1'b1} : burst_len;

  // cpu_en must drop in the same cycle the PC matches, so it stays combinational.
  assign cpu_en    = !reset && ((r_state == S_RUN) || (r_state == S_STEP)) && !w_bp_hit;
  assign halted    = (r_state == S_HALT) || (r_state == S_BREAK);
  assign step_done = r_step_done;
  assign cycle_cnt = r_cycle_cnt;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= S_RUN;
      r_chg_sync  <= '0;
      r_stp_sync  <= '0;
      r_stp_prev  <= 1'b0;
      r_count     <= '0;
      r_bp_mask   <= 1'b0;
      r_step_done <= 1'b0;
      r_cycle_cnt <= '0;
    end else begin
      r_chg_sync  <= {r_chg_sync[SYNC_STAGES-2:0], change};
      r_stp_sync  <= {r_stp_sync[SYNC_STAGES-2:0], step};
      r_stp_prev  <= r_stp_sync[SYNC_STAGES-1];
      r_step_done <= 1'b0;
      if (cpu_en) begin
        r_cycle_cnt <= r_cycle_cnt + 32'd1;
      end

      case (r_state)
        S_RUN: begin
          if (w_bp_hit) begin
            r_state <= S_BREAK;
          end else if (w_chg) begin
            r_state <= S_HALT;
          end
        end
        S_HALT: begin
          if (!w_chg) begin
            r_state <= S_RUN;
          end else if (w_step_rise) begin
            r_state <= S_STEP;
            r_count <= w_load;
          end
        end
        S_STEP: begin
          // The mask only covers the first cycle after leaving BREAK.
          r_bp_mask <= 1'b0;
          if (w_bp_hit) begin
            r_state <= S_BREAK;
            r_count <= '0;
          end else if (r_count == {{(CNT_W-1){1'b0}}, 1'b1}) begin
            r_state     <= S_HALT;
            r_count     <= '0;
            r_step_done <= 1'b1;
          end else begin
            r_count <= r_count - {{(CNT_W-1){1'b0}}, 1'b1};
          end
        end
        S_BREAK: begin
          if (w_step_rise) begin
            r_state   <= S_STEP;
            r_count   <= w_load;
            r_bp_mask <= 1'b1;
          end else if (!bp_en) begin
            r_state <= w_chg ? S_HALT : S_RUN;
          end
        end
        default: r_state <= S_RUN;
      endcase
    end
  end

endmodule

`default_nettype wire
